// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, clock out 8 data bits,
// odd parity and stop on device clock edges, read the device ACK, then wait for an idle line.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam int unsigned CntMax = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                     : TIMEOUT_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [2:0] {
    StIdle, StInhibit, StStart, StShift, StAck, StWaitIdle
  } state_e;

  state_e          r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic [3:0]      r_idx, w_idx_d;
  logic [9:0]      r_frame, w_frame_d;
  logic            r_ack_bad, w_ack_bad_d;
  logic [2:0]      r_clk_sync, r_data_sync;
  logic            r_clk_oe, r_data_oe, r_ready, r_busy, r_done, r_ack_err, r_timeout;
  logic            w_clk_oe_d, w_data_oe_d, w_done_d, w_ack_err_d, w_timeout_d;
  logic            w_fe, w_to, w_inh_end, w_line_idle;

  assign w_fe        = r_clk_sync[2] & ~r_clk_sync[1];
  assign w_to        = (r_cnt == CntW'(TIMEOUT_CYCLES - 1));
  assign w_inh_end   = (r_cnt == CntW'(INHIBIT_CYCLES - 1));
  assign w_line_idle = r_clk_sync[2] & r_data_sync[2];

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt + CntW'(1);
    w_idx_d     = r_idx;
    w_frame_d   = r_frame;
    w_ack_bad_d = r_ack_bad;
    w_clk_oe_d  = 1'b0;
    w_data_oe_d = 1'b0;
    w_done_d    = 1'b0;
    w_ack_err_d = 1'b0;
    w_timeout_d = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_cnt_d = '0;
        if (tx_valid && r_ready) begin
          w_state_d  = StInhibit;
          w_frame_d  = {1'b1, ~^tx_data, tx_data};
          w_clk_oe_d = 1'b1;
        end
      end
      StInhibit: begin
        w_clk_oe_d = 1'b1;
        if (w_inh_end) begin
          w_state_d   = StStart;
          w_data_oe_d = 1'b1;
          w_cnt_d     = '0;
        end
      end
      StStart: begin
        w_state_d   = StShift;
        w_idx_d     = '0;
        w_cnt_d     = '0;
        w_data_oe_d = r_data_oe;
      end
      StShift: begin
        w_data_oe_d = r_data_oe;
        if (w_to) begin
          w_state_d   = StIdle;
          w_data_oe_d = 1'b0;
          w_timeout_d = 1'b1;
        end else if (w_fe) begin
          w_data_oe_d = ~r_frame[r_idx];
          w_idx_d     = r_idx + 4'd1;
          if (r_idx == 4'd9) w_state_d = StAck;
        end
      end
      StAck: begin
        w_data_oe_d = r_data_oe;
        if (w_to) begin
          w_state_d   = StIdle;
          w_data_oe_d = 1'b0;
          w_timeout_d = 1'b1;
        end else if (w_fe) begin
          w_ack_bad_d = r_data_sync[1];
          w_state_d   = StWaitIdle;
        end
      end
      StWaitIdle: begin
        // Completion takes priority over a coincident timeout.
        if (w_line_idle) begin
          w_state_d   = StIdle;
          w_done_d    = 1'b1;
          w_ack_err_d = r_ack_bad;
        end else if (w_to) begin
          w_state_d   = StIdle;
          w_timeout_d = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_frame     <= '0;
      r_ack_bad   <= 1'b0;
      r_clk_sync  <= 3'b111;
      r_data_sync <= 3'b111;
      r_clk_oe    <= 1'b0;
      r_data_oe   <= 1'b0;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ack_err   <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_idx       <= w_idx_d;
      r_frame     <= w_frame_d;
      r_ack_bad   <= w_ack_bad_d;
      r_clk_sync  <= {r_clk_sync[1:0], ps2_clk_in};
      r_data_sync <= {r_data_sync[1:0], ps2_data_in};
      r_clk_oe    <= w_clk_oe_d;
      r_data_oe   <= w_data_oe_d;
      // Ready stays low during the status pulse so it reasserts one cycle later.
      r_ready     <= (w_state_d == StIdle) & ~w_done_d & ~w_timeout_d;
      r_busy      <= (w_state_d != StIdle);
      r_done      <= w_done_d;
      r_ack_err   <= w_ack_err_d;
      r_timeout   <= w_timeout_d;
    end
  end

  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign tx_ready    = r_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign ack_err     = r_ack_err;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device drives the clock and ACK, and every bit the
// device samples is compared with a frame built arithmetically from the command byte.
module tb_ps2_host_tx;
  localparam int unsigned Inh = 8;
  localparam int unsigned To  = 1000;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, ack_err, timeout;

  int n_checks = 0, n_pass = 0;
  int n_done = 0, n_ackerr = 0, n_to = 0;
  int exp_done = 0, exp_ackerr = 0, exp_to = 0;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(Inh), .TIMEOUT_CYCLES(To)) u_dut (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done),
    .ack_err    (ack_err),
    .timeout    (timeout)
  );

  always @(negedge clk) begin
    if (done)    n_done++;
    if (ack_err) n_ackerr++;
    if (timeout) n_to++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Line levels the device sees: start(0), d0..d7, odd parity, stop(1).
  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0), b, 1'b0};
  endfunction

  // Accept a byte and check the inhibit / request-to-send sequence; ends in the first
  // cycle after clock release.
  task automatic start_req(input logic [7:0] b, input bit dup);
    int n = 0;
    while (!tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_req", tx_ready, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    check("clk_oe_after_accept", ps2_clk_oe, 1);
    check("ready_low_when_busy", tx_ready, 0);
    if (dup) begin
      tx_data  = ~b;
      tx_valid = 1'b1;
    end
    n = 0;
    while (ps2_data_oe == 1'b0 && ps2_clk_oe == 1'b1 && n < int'(Inh) + 20) begin
      n++;
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data  = b;
    end
    check("inhibit_len", n, Inh);
    check("start_oe", {ps2_clk_oe, ps2_data_oe}, 2'b11);
    @(negedge clk);
    check("release_oe", {ps2_clk_oe, ps2_data_oe}, 2'b01);
  endtask

  // Device clocking 11 edges; returns early (clock held low) after edge abort_at.
  task automatic dev_run(input bit nack, input int half, input int abort_at,
                         output logic [10:0] got);
    got    = '0;
    got[0] = ps2_data_in;
    for (int i = 1; i <= 11; i++) begin
      repeat (half) @(negedge clk);
      if (i == 11) dev_data = nack;
      dev_clk = 1'b0;
      repeat (half) @(negedge clk);
      if (i == abort_at) return;
      if (i <= 10) got[i] = ps2_data_in;
      dev_clk = 1'b1;
    end
    repeat (2) @(negedge clk);
    dev_data = 1'b1;
  endtask

  task automatic wait_done(input bit nack);
    int n = 0;
    while (!done && !timeout && n < 2 * int'(To)) begin
      @(negedge clk);
      n++;
    end
    check("done_pulse", done, 1);
    check("ack_err_with_done", ack_err, nack);
    check("no_timeout_on_done", timeout, 0);
    check("idle_on_done", {busy, tx_ready, ps2_clk_oe, ps2_data_oe}, 4'b0000);
    @(negedge clk);
    check("pulses_one_cycle", {done, ack_err}, 2'b00);
    check("ready_after_pulse", tx_ready, 1);
  endtask

  task automatic full_frame(input logic [7:0] b, input bit nack, input bit dup);
    logic [10:0] got;
    logic [10:0] exp;
    exp = exp_frame(b);
    start_req(b, dup);
    dev_run(nack, int'($urandom_range(12, 25)), 0, got);
    check("frame_bits", got, exp);
    check("parity_bit", got[9], exp[9]);
    wait_done(nack);
    exp_done++;
    if (nack) exp_ackerr++;
  endtask

  initial begin
    logic [10:0] got;
    int n;
    #200_000;
    $display("FAIL watchdog: got no finish expected finish by 200us");
    $fatal(1);
  end

  initial begin
    logic [10:0] got;
    int n;
    repeat (3) @(negedge clk);
    check("reset_outputs", {ps2_clk_oe, ps2_data_oe, tx_ready, busy, done, ack_err, timeout},
          7'b0010000);
    clrn = 1'b1;
    @(negedge clk);

    full_frame(8'hED, 1'b0, 1'b0);
    full_frame(8'h07, 1'b1, 1'b0);
    full_frame(8'hFF, 1'b0, 1'b1);

    // Device never clocks: abort after the timeout window.
    start_req(8'hA5, 1'b0);
    n = 0;
    while (!timeout && n < int'(To) + 50) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency", n, To);
    check("timeout_state", {ps2_clk_oe, ps2_data_oe, done}, 3'b000);
    exp_to++;
    @(negedge clk);
    check("timeout_one_cycle", timeout, 0);
    full_frame(8'($urandom), 1'($urandom), 1'b0);

    // Reset during bit 5 of 0x55.
    start_req(8'h55, 1'b0);
    dev_run(1'b0, 15, 5, got);
    clrn = 1'b0;
    #1;
    check("reset_releases_lines", {ps2_clk_oe, ps2_data_oe, busy, tx_ready}, 4'b0001);
    repeat (3) @(negedge clk);
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    clrn     = 1'b1;
    repeat (2) @(negedge clk);
    full_frame(8'h55, 1'b0, 1'b0);

    full_frame(8'hED, 1'b0, 1'b0);
    full_frame(8'h02, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) full_frame(8'($urandom), 1'($urandom), 1'b0);

    repeat (2) @(negedge clk);
    check("done_count", n_done, exp_done);
    check("ack_err_count", n_ackerr, exp_ackerr);
    check("timeout_count", n_to, exp_to);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
